// File: rtl/regfile_writeback.sv
// Register file write-back arbiter: merges single-cycle results (A) with a buffered long-latency stream (B).
// Optional WB_BYPASS_EN adds combinational write-through forwarding for the s/t decode operands.
module regfile_writeback #(
    parameter int ADDR_SIZE  = 5,
    parameter int WORD_SIZE  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic [WORD_SIZE-1:0] a_data,
    output logic                 a_stall,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic [WORD_SIZE-1:0] b_data,
    input  logic                 issue_valid,
    input  logic [ADDR_SIZE-1:0] issue_addr,
    input  logic [ADDR_SIZE-1:0] s_addr,
    output logic                 s_busy,
    input  logic [ADDR_SIZE-1:0] t_addr,
    output logic                 t_busy,
`ifdef WB_BYPASS_EN
    input  logic [WORD_SIZE-1:0] s_rf_data,
    input  logic [WORD_SIZE-1:0] t_rf_data,
    output logic [WORD_SIZE-1:0] s_fwd_data,
    output logic [WORD_SIZE-1:0] t_fwd_data,
`endif
    output logic                 d_we,
    output logic [ADDR_SIZE-1:0] d_addr,
    output logic [WORD_SIZE-1:0] d_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int NREG  = 1 << ADDR_SIZE;

    logic [ADDR_SIZE-1:0] fifo_addr [FIFO_DEPTH];
    logic [WORD_SIZE-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr, rd_ptr;
    logic [7:0]           starve_cnt, starve_cnt_nxt;
    logic [NREG-1:0]      pending;

    logic                 fifo_empty, fifo_full;
    logic                 take_a, pop, push;
    logic [ADDR_SIZE-1:0] head_addr;
    logic [WORD_SIZE-1:0] head_data;
    logic                 vld_p0;
    logic [ADDR_SIZE-1:0] addr_p0;
    logic [WORD_SIZE-1:0] data_p0;
    logic                 vld_p1;
    logic [ADDR_SIZE-1:0] addr_p1;
    logic [WORD_SIZE-1:0] data_p1;
    logic                 stall_p1;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head_addr  = fifo_addr[rd_ptr[PTR_W-1:0]];
    assign head_data  = fifo_data[rd_ptr[PTR_W-1:0]];

    assign take_a  = a_valid && !stall_p1;
    assign pop     = !take_a && !fifo_empty;
    assign push    = b_valid && !fifo_full;
    assign b_ready = !fifo_full;

    // Stage p0: arbitration between A and the FIFO head
    always_comb begin
        vld_p0  = 1'b0;
        addr_p0 = '0;
        data_p0 = '0;
        if (take_a) begin
            vld_p0  = 1'b1;
            addr_p0 = a_addr;
            data_p0 = a_data;
        end else if (pop) begin
            vld_p0  = 1'b1;
            addr_p0 = head_addr;
            data_p0 = head_data;
        end
    end

    // The counter only runs while B waits behind an A write, so reaching the limit implies a non-empty FIFO.
    always_comb begin
        if (pop || fifo_empty)
            starve_cnt_nxt = '0;
        else
            starve_cnt_nxt = starve_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            starve_cnt <= '0;
            stall_p1   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            starve_cnt <= starve_cnt_nxt;
            stall_p1   <= (starve_cnt_nxt == 8'(STARVE_MAX));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr[PTR_W-1:0]] <= b_addr;
            fifo_data[wr_ptr[PTR_W-1:0]] <= b_data;
        end
    end

    // Issue is applied after the commit clear so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (pop && head_addr != '0)
                pending[head_addr] <= 1'b0;
            if (issue_valid && issue_addr != '0)
                pending[issue_addr] <= 1'b1;
        end
    end

    // Stage p1: registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1  <= vld_p0 && (addr_p0 != '0);
            addr_p1 <= addr_p0;
            data_p1 <= data_p0;
        end
    end

    assign d_we    = vld_p1;
    assign d_addr  = addr_p1;
    assign d_data  = data_p1;
    assign a_stall = stall_p1;

    assign s_busy = (s_addr != '0) && pending[s_addr];
    assign t_busy = (t_addr != '0) && pending[t_addr];

`ifdef WB_BYPASS_EN
    assign s_fwd_data = (vld_p1 && addr_p1 == s_addr && s_addr != '0) ? data_p1 : s_rf_data;
    assign t_fwd_data = (vld_p1 && addr_p1 == t_addr && t_addr != '0) ? data_p1 : t_rf_data;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized bench for regfile_writeback against a queue-based reference model of the write-back rules.
// Define WB_BYPASS_EN for both files to also exercise the forwarding outputs.
module tb_regfile_writeback;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, a_stall, b_valid, b_ready, issue_valid;
    logic          s_busy, t_busy, d_we;
    logic [AW-1:0] a_addr, b_addr, issue_addr, s_addr, t_addr, d_addr;
    logic [DW-1:0] a_data, b_data, d_data;
`ifdef WB_BYPASS_EN
    logic [DW-1:0] s_rf_data, t_rf_data, s_fwd_data, t_fwd_data;
`endif

    regfile_writeback #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_stall(a_stall),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .s_addr(s_addr), .s_busy(s_busy), .t_addr(t_addr), .t_busy(t_busy),
`ifdef WB_BYPASS_EN
        .s_rf_data(s_rf_data), .t_rf_data(t_rf_data), .s_fwd_data(s_fwd_data), .t_fwd_data(t_fwd_data),
`endif
        .d_we(d_we), .d_addr(d_addr), .d_data(d_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    int            total = 0;
    int            bad   = 0;
    ent_t          mq[$];
    logic [AW-1:0] outstanding[$];
    int            m_cnt;
    bit            m_stall;
    bit [31:0]     m_pend;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cnt   = 0;
        m_stall = 0;
        m_pend  = '0;
        m_we    = 0;
        m_addr  = '0;
        m_data  = '0;
    endtask

    // One clock: check combinational outputs, advance the model, then check the registered write port.
    task automatic cycle();
        ent_t e;
        bit   took_a, popped;
        int   sz0;
        #1;
        if (!rst) begin
            check("b_ready", 64'(b_ready), 64'(mq.size() < DEPTH));
            check("a_stall", 64'(a_stall), 64'(m_stall));
            check("s_busy", 64'(s_busy), 64'(s_addr != 0 && m_pend[s_addr]));
            check("t_busy", 64'(t_busy), 64'(t_addr != 0 && m_pend[t_addr]));
`ifdef WB_BYPASS_EN
            check("s_fwd", 64'(s_fwd_data), 64'((m_we && m_addr == s_addr && s_addr != 0) ? m_data : s_rf_data));
            check("t_fwd", 64'(t_fwd_data), 64'((m_we && m_addr == t_addr && t_addr != 0) ? m_data : t_rf_data));
`endif
        end
        if (rst) begin
            model_reset();
        end else begin
            sz0    = mq.size();
            took_a = a_valid && !m_stall;
            popped = 0;
            m_we   = 0;
            if (took_a) begin
                m_we   = (a_addr != 0);
                m_addr = a_addr;
                m_data = a_data;
            end else if (sz0 > 0) begin
                e      = mq.pop_front();
                popped = 1;
                m_we   = (e.addr != 0);
                m_addr = e.addr;
                m_data = e.data;
                if (e.addr != 0) m_pend[e.addr] = 0;
            end
            if (b_valid && sz0 < DEPTH) begin
                e.addr = b_addr;
                e.data = b_data;
                mq.push_back(e);
            end
            if (popped || sz0 == 0) m_cnt = 0;
            else if (took_a) m_cnt++;
            m_stall = (m_cnt == SMAX);
            if (issue_valid && issue_addr != 0) m_pend[issue_addr] = 1;
        end
        @(posedge clk);
        #1;
        check("d_we", 64'(d_we), 64'(m_we));
        if (m_we) begin
            check("d_addr", 64'(d_addr), 64'(m_addr));
            check("d_data", 64'(d_data), 64'(m_data));
        end
    endtask

    task automatic do_reset();
        rst = 1; a_valid = 0; b_valid = 0; issue_valid = 0;
        cycle();
        cycle();
        rst = 0;
        outstanding.delete();
        check("rst_d_we", 64'(d_we), 64'(0));
        check("rst_b_ready", 64'(b_ready), 64'(1));
        check("rst_a_stall", 64'(a_stall), 64'(0));
    endtask

    initial begin
        a_valid = 0; a_addr = '0; a_data = '0;
        b_valid = 0; b_addr = '0; b_data = '0;
        issue_valid = 0; issue_addr = '0; s_addr = '0; t_addr = '0;
`ifdef WB_BYPASS_EN
        s_rf_data = '0; t_rf_data = '0;
`endif
        do_reset();

        // No register is busy after reset
        for (int i = 0; i < 32; i++) begin
            s_addr = AW'(i);
            t_addr = AW'(31 - i);
            cycle();
        end

        // Plain A write, visible for exactly one cycle
        a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
        cycle();
        check("a_write_we", 64'(d_we), 64'(1));
        check("a_write_addr", 64'(d_addr), 64'(5));
        check("a_write_data", 64'(d_data), 64'(32'hDEADBEEF));
        a_valid = 0;
        cycle();
        check("a_write_once", 64'(d_we), 64'(0));

        // Register 0 writes from both ports are suppressed
        a_valid = 1; a_addr = 0; a_data = 32'h5555;
        cycle();
        check("a_zero_we", 64'(d_we), 64'(0));
        a_valid = 0; b_valid = 1; b_addr = 0; b_data = 32'hAAAA;
        cycle();
        b_valid = 0;
        cycle();
        check("b_zero_we", 64'(d_we), 64'(0));

        // Scoreboard set by issue, cleared by the committing pop
        issue_valid = 1; issue_addr = 7; s_addr = 7;
        cycle();
        issue_valid = 0;
        check("issue_busy", 64'(s_busy), 64'(1));
        b_valid = 1; b_addr = 7; b_data = 32'h1234;
        cycle();
        b_valid = 0;
        cycle();
        check("b_commit_addr", 64'(d_addr), 64'(7));
        check("b_commit_data", 64'(d_data), 64'(32'h1234));
        check("b_commit_busy", 64'(s_busy), 64'(0));

        // Fill the FIFO while A occupies the port
        a_valid = 1; a_addr = 2;
        for (int i = 0; i < 5; i++) begin
            b_valid = 1; b_addr = AW'(10 + i); b_data = 32'(i);
            a_data = 32'(100 + i);
            cycle();
            check("fill_b_ready", 64'(b_ready), 64'(i < 3));
        end
        a_valid = 0;
        cycle();
        check("full_pop_b_ready", 64'(b_ready), 64'(1));
        b_valid = 0;

        // Reset with entries queued discards them
        do_reset();
        cycle();
        check("rst_discard_we", 64'(d_we), 64'(0));

        // Starvation: A held continuously with one B entry waiting
        a_valid = 1; a_addr = 3; a_data = 32'h11;
        b_valid = 1; b_addr = 9; b_data = 32'h99;
        cycle();
        b_valid = 0;
        for (int i = 1; i <= SMAX; i++) begin
            cycle();
            check("starve_stall", 64'(a_stall), 64'(i == SMAX));
        end
        cycle();
        check("starve_b_addr", 64'(d_addr), 64'(9));
        check("starve_b_data", 64'(d_data), 64'(32'h99));
        check("starve_release", 64'(a_stall), 64'(0));
        cycle();
        check("starve_a_resume", 64'(d_addr), 64'(3));
        a_valid = 0;
        cycle();

        // Randomized traffic honouring the issue/return contract
        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] r;
            if (!m_stall) begin
                a_valid = ($urandom_range(0, 99) < 60);
                a_addr  = AW'($urandom_range(0, 31));
                a_data  = $urandom;
            end
            r = AW'($urandom_range(0, 31));
            issue_valid = ($urandom_range(0, 3) == 0) && !m_pend[r];
            issue_addr  = r;
            b_valid = (outstanding.size() > 0) && ($urandom_range(0, 99) < 50);
            b_addr  = (outstanding.size() > 0) ? outstanding[0] : '0;
            b_data  = $urandom;
            s_addr  = AW'($urandom_range(0, 31));
            t_addr  = AW'($urandom_range(0, 31));
`ifdef WB_BYPASS_EN
            s_rf_data = $urandom;
            t_rf_data = $urandom;
`endif
            rst = ($urandom_range(0, 499) == 0);
            if (!rst && b_valid && mq.size() < DEPTH) void'(outstanding.pop_front());
            if (!rst && issue_valid) outstanding.push_back(issue_addr);
            cycle();
            if (rst) begin
                rst = 0;
                outstanding.delete();
                check("rand_rst_we", 64'(d_we), 64'(0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
